// File: rtl/noc_defs.sv
// Shared NoC definitions: address/router-id widths and flit field positions,
// used by spike_injector, the router and the network interface.
package noc_defs;

  localparam int NUM_BITS_ADDR = 12;
  localparam int NODE_BITS     = 4;
  localparam int FLIT_BITS     = NODE_BITS + NUM_BITS_ADDR;

  // Flit layout: {dest_node, source_neuron_address}
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = ADDR_LSB + NUM_BITS_ADDR - 1;
  localparam int NODE_LSB = ADDR_MSB + 1;
  localparam int NODE_MSB = NODE_LSB + NODE_BITS - 1;

  typedef enum logic {
    ROUTE_NOC   = 1'b0,
    ROUTE_LOCAL = 1'b1
  } route_e;

endpackage

// File: rtl/flit_fifo.sv
// Valid/ready FIFO with extra-MSB pointers; head is registered storage, so a
// write becomes visible on the read side one cycle later.
module flit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_wr_ready = !w_full;
  assign o_rd_valid = !w_empty;
  assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push     = i_wr_valid && !w_full;
  assign w_pop      = !w_empty && i_rd_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/spike_injector.sv
// Routes accepted spikes either to the local strobe or into the NoC injection
// queue, and counts flits taken by the router (saturating at 0xFFFF).
module spike_injector
  import noc_defs::*;
#(
  parameter int NUM_BITS_ADDR = noc_defs::NUM_BITS_ADDR,
  parameter int NODE_BITS     = noc_defs::NODE_BITS,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           spike_valid,
  output logic                           spike_ready,
  input  logic [NUM_BITS_ADDR-1:0]       source_neuron_address,
  input  logic                           stays,
  input  logic [NODE_BITS-1:0]           dest_node,
  output logic                           local_valid,
  output logic [NUM_BITS_ADDR-1:0]       local_addr,
  output logic                           flit_valid,
  input  logic                           flit_ready,
  output logic [NODE_BITS+NUM_BITS_ADDR-1:0] flit_data,
  output logic [15:0]                    inject_count
);

  logic                               w_fifo_ready;
  logic                               w_accept;
  logic                               w_local;
  logic                               w_push_req;
  logic [NODE_BITS+NUM_BITS_ADDR-1:0] w_flit_in;
  logic                               r_local_valid;
  logic [NUM_BITS_ADDR-1:0]           r_local_addr;
  logic [15:0]                        r_inject_count;

  assign w_local     = (route_e'(stays) == ROUTE_LOCAL);
  assign spike_ready = RESET_N && (w_local || w_fifo_ready);
  assign w_accept    = spike_valid && spike_ready;
  assign w_push_req  = RESET_N && spike_valid && !w_local;
  assign w_flit_in   = {dest_node, source_neuron_address};

  flit_fifo #(
    .WIDTH (NODE_BITS + NUM_BITS_ADDR),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .i_wr_valid (w_push_req),
    .o_wr_ready (w_fifo_ready),
    .i_wr_data  (w_flit_in),
    .o_rd_valid (flit_valid),
    .i_rd_ready (flit_ready),
    .o_rd_data  (flit_data)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_local_valid  <= 1'b0;
      r_local_addr   <= '0;
      r_inject_count <= '0;
    end else begin
      r_local_valid <= w_accept && w_local;
      if (w_accept && w_local) r_local_addr <= source_neuron_address;
      if (flit_valid && flit_ready && (r_inject_count != 16'hFFFF))
        r_inject_count <= r_inject_count + 16'd1;
    end
  end

  assign local_valid  = r_local_valid;
  assign local_addr   = r_local_addr;
  assign inject_count = r_inject_count;

endmodule

// File: tb/tb_spike_injector.sv
// Directed bench for spike_injector: local path, injection, back-pressure,
// concurrent push/pop across wrap, count saturation and mid-run reset.
module tb_spike_injector;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        spike_valid;
  logic        spike_ready;
  logic [11:0] source_neuron_address;
  logic        stays;
  logic [3:0]  dest_node;
  logic        local_valid;
  logic [11:0] local_addr;
  logic        flit_valid;
  logic        flit_ready;
  logic [15:0] flit_data;
  logic [15:0] inject_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  spike_injector dut (
    .CLK                   (CLK),
    .RESET_N               (RESET_N),
    .spike_valid           (spike_valid),
    .spike_ready           (spike_ready),
    .source_neuron_address (source_neuron_address),
    .stays                 (stays),
    .dest_node             (dest_node),
    .local_valid           (local_valid),
    .local_addr            (local_addr),
    .flit_valid            (flit_valid),
    .flit_ready            (flit_ready),
    .flit_data             (flit_data),
    .inject_count          (inject_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] d, input logic [11:0] a);
    spike_valid           = v;
    stays                 = s;
    dest_node             = d;
    source_neuron_address = a;
    #1;
  endtask

  initial begin
    RESET_N = 1'b0;
    flit_ready = 1'b0;
    drive(1'b1, 1'b1, 4'h0, 12'h000);
    step();
    step();
    check("rst_spike_ready", spike_ready, 0);
    check("rst_flit_valid", flit_valid, 0);
    check("rst_local_valid", local_valid, 0);
    check("rst_local_addr", local_addr, 0);
    check("rst_count", inject_count, 0);

    // Local path
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    RESET_N = 1'b1;
    #1;
    check("idle_ready", spike_ready, 1);
    drive(1'b1, 1'b1, 4'h0, 12'h005);
    check("local_ready", spike_ready, 1);
    step();
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    check("local_valid_hi", local_valid, 1);
    check("local_addr", local_addr, 12'h005);
    check("local_no_flit", flit_valid, 0);
    step();
    check("local_valid_lo", local_valid, 0);
    check("local_no_flit2", flit_valid, 0);

    // Injection and count
    flit_ready = 1'b1;
    drive(1'b1, 1'b0, 4'h3, 12'hABC);
    check("inj_empty_no_bypass", flit_valid, 0);
    step();
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    check("inj_flit_valid", flit_valid, 1);
    check("inj_flit_data", flit_data, 16'h3ABC);
    check("inj_count0", inject_count, 0);
    step();
    check("inj_count1", inject_count, 1);
    check("inj_drained", flit_valid, 0);

    // Back-pressure: 5 offered, 4 accepted
    flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 4'(i + 1), 12'(12'h100 + i));
      check($sformatf("bp_ready_%0d", i), spike_ready, (i < 4) ? 1 : 0);
      step();
    end
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    check("bp_full_ready", spike_ready, 0);
    check("bp_head", flit_data, 16'h1100);
    step();
    check("bp_head_stable", flit_data, 16'h1100);
    drive(1'b0, 1'b1, 4'h0, 12'h000);
    check("bp_local_when_full", spike_ready, 1);
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    flit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_valid_%0d", i), flit_valid, 1);
      check($sformatf("bp_data_%0d", i), flit_data, {4'(i + 1), 12'(12'h100 + i)});
      step();
      if (i == 0) check("bp_ready_rises", spike_ready, 1);
    end
    check("bp_empty", flit_valid, 0);
    check("bp_count5", inject_count, 5);

    // Concurrency across pointer wrap: 10 packets, 2 queued throughout
    flit_ready = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      drive(1'b1, 1'b0, 4'(p), 12'(12'h200 + p));
      step();
      exp_q.push_back({4'(p), 12'(12'h200 + p)});
    end
    flit_ready = 1'b1;
    for (int p = 2; p < 10; p++) begin
      drive(1'b1, 1'b0, 4'(p), 12'(12'h200 + p));
      check($sformatf("cc_valid_%0d", p), flit_valid, 1);
      check($sformatf("cc_data_%0d", p), flit_data, exp_q[0]);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back({4'(p), 12'(12'h200 + p)});
    end
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cc_tail_valid_%0d", i), flit_valid, 1);
      check($sformatf("cc_tail_data_%0d", i), flit_data, exp_q[0]);
      step();
      void'(exp_q.pop_front());
    end
    check("cc_empty", flit_valid, 0);
    check("cc_count15", inject_count, 15);

    // Saturation
    flit_ready = 1'b0;
    force dut.r_inject_count = 16'hFFFE;
    #1;
    release dut.r_inject_count;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'h5, 12'(12'h300 + i));
      step();
    end
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    check("sat_preload", inject_count, 16'hFFFE);
    flit_ready = 1'b1;
    step();
    check("sat_reach", inject_count, 16'hFFFF);
    step();
    step();
    check("sat_hold", inject_count, 16'hFFFF);
    check("sat_drained", flit_valid, 0);

    // Reset with 3 queued discards them
    flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'h6, 12'(12'h400 + i));
      step();
    end
    drive(1'b0, 1'b0, 4'h0, 12'h000);
    check("mr_queued", flit_valid, 1);
    RESET_N = 1'b0;
    flit_ready = 1'b1;
    step();
    check("mr_flit_valid", flit_valid, 0);
    check("mr_count", inject_count, 0);
    check("mr_ready", spike_ready, 0);
    RESET_N = 1'b1;
    step();
    step();
    check("mr_nothing_emitted", flit_valid, 0);
    check("mr_count_stays0", inject_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
